// File: rtl/vga_plot_sink.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_plot_sink
//  Purpose  : Receiving end of the VGA plot interface. Captures plotted
//             pixels into a 160x120 framebuffer, counts accepted/rejected
//             plots, clears the framebuffer on request and streams it back
//             out in raster order over a valid/ready interface.
//  Options  : VGA_PLOT_SINK_CHECKSUM_EN - builds the rolling checksum over
//             dumped beats; when undefined dump_checksum is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_plot_sink #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          vga_x,
    input  logic [6:0]          vga_y,
    input  logic [COLOUR_W-1:0] vga_colour,
    input  logic                vga_plot,
    input  logic                clear_start,
    input  logic                dump_start,
    output logic [7:0]          dump_x,
    output logic [6:0]          dump_y,
    output logic [COLOUR_W-1:0] dump_colour,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic                dump_last,
    output logic                busy,
    output logic                done,
    output logic [15:0]         plot_count,
    output logic [7:0]          reject_count,
    output logic [15:0]         dump_checksum
);

    localparam int                  c_ADDR_W    = 15;
    localparam int                  c_NPIX      = SCREEN_W * SCREEN_H;
    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(c_NPIX - 1);
    localparam logic [7:0]          c_X_LAST    = 8'(SCREEN_W - 1);
    localparam logic [6:0]          c_Y_LAST    = 7'(SCREEN_H - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_CLEAR = 2'd1;
    localparam logic [1:0] c_S_DUMP  = 2'd2;

    logic [1:0]          r_state;
    logic                r_busy;
    logic                r_done;
    logic [c_ADDR_W-1:0] r_cnt_addr;
    logic [7:0]          r_cnt_x;
    logic [6:0]          r_cnt_y;
    logic                r_issued_all;
    logic                r_dump_valid;
    logic                r_dump_last;
    logic [7:0]          r_dump_x;
    logic [6:0]          r_dump_y;
    logic [COLOUR_W-1:0] r_rd_data;
    logic [15:0]         r_plot_count;
    logic [7:0]          r_reject_count;

    logic [COLOUR_W-1:0] r_fb [0:c_NPIX-1];

    logic                w_plot_in_range;
    logic                w_plot_ok;
    logic [c_ADDR_W-1:0] w_plot_addr;
    logic                w_fb_we;
    logic [c_ADDR_W-1:0] w_fb_waddr;
    logic [COLOUR_W-1:0] w_fb_wdata;
    logic                w_xfer;
    logic                w_issue;
    logic                w_dump_accept;

    // Plot qualification; rows never wrap because x and y are range-checked separately
    always_comb begin
        w_plot_in_range = (vga_x <= c_X_LAST) && (vga_y <= c_Y_LAST);
        w_plot_ok       = vga_plot && w_plot_in_range && (r_state != c_S_CLEAR);
        w_plot_addr     = c_ADDR_W'(vga_y) * c_ADDR_W'(SCREEN_W) + c_ADDR_W'(vga_x);
    end

    // Single write port: CLEAR owns it, otherwise accepted plots use it
    always_comb begin
        w_fb_we    = 1'b0;
        w_fb_waddr = w_plot_addr;
        w_fb_wdata = vga_colour;
        if (!rst) begin
            if (r_state == c_S_CLEAR) begin
                w_fb_we    = 1'b1;
                w_fb_waddr = r_cnt_addr;
                w_fb_wdata = '0;
            end else if (w_plot_ok) begin
                w_fb_we = 1'b1;
            end
        end
    end

    // Stream handshake: fetch a new beat when the output slot is empty or draining
    always_comb begin
        w_xfer        = r_dump_valid && dump_ready;
        w_issue       = (r_state == c_S_DUMP) && !r_issued_all && (!r_dump_valid || dump_ready);
        w_dump_accept = (r_state == c_S_IDLE) && !clear_start && dump_start;
    end

    // Framebuffer write port (contents deliberately not reset)
    always_ff @(posedge clk) begin
        if (w_fb_we) begin
            r_fb[w_fb_waddr] <= w_fb_wdata;
        end
    end

    // Registered read port; a same-cycle write to this address returns the old value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (w_issue) begin
            r_rd_data <= r_fb[r_cnt_addr];
        end
    end

    // Control FSM: address sequencing for CLEAR/DUMP and registered stream outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cnt_addr   <= '0;
            r_cnt_x      <= '0;
            r_cnt_y      <= '0;
            r_issued_all <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_last  <= 1'b0;
            r_dump_x     <= '0;
            r_dump_y     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (clear_start) begin
                        r_state    <= c_S_CLEAR;
                        r_busy     <= 1'b1;
                        r_cnt_addr <= '0;
                    end else if (dump_start) begin
                        r_state      <= c_S_DUMP;
                        r_busy       <= 1'b1;
                        r_cnt_addr   <= '0;
                        r_cnt_x      <= '0;
                        r_cnt_y      <= '0;
                        r_issued_all <= 1'b0;
                    end
                end
                c_S_CLEAR: begin
                    if (r_cnt_addr == c_LAST_ADDR) begin
                        r_state <= c_S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt_addr <= r_cnt_addr + 1'b1;
                    end
                end
                c_S_DUMP: begin
                    if (w_issue) begin
                        r_dump_valid <= 1'b1;
                        r_dump_x     <= r_cnt_x;
                        r_dump_y     <= r_cnt_y;
                        r_dump_last  <= (r_cnt_addr == c_LAST_ADDR);
                        if (r_cnt_addr == c_LAST_ADDR) begin
                            r_issued_all <= 1'b1;
                        end else begin
                            r_cnt_addr <= r_cnt_addr + 1'b1;
                            if (r_cnt_x == c_X_LAST) begin
                                r_cnt_x <= '0;
                                r_cnt_y <= r_cnt_y + 7'd1;
                            end else begin
                                r_cnt_x <= r_cnt_x + 8'd1;
                            end
                        end
                    end else if (w_xfer) begin
                        r_dump_valid <= 1'b0;
                    end
                    if (w_xfer && r_dump_last) begin
                        r_state <= c_S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating accepted/rejected plot counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_plot_count   <= '0;
            r_reject_count <= '0;
        end else if (vga_plot) begin
            if (w_plot_ok) begin
                if (r_plot_count != 16'hFFFF) begin
                    r_plot_count <= r_plot_count + 16'd1;
                end
            end else if (r_reject_count != 8'hFF) begin
                r_reject_count <= r_reject_count + 8'd1;
            end
        end
    end

`ifdef VGA_PLOT_SINK_CHECKSUM_EN
    logic [15:0] r_checksum;

    // Rotate-left-and-add checksum over every transferred beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_dump_accept) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= {r_checksum[14:0], r_checksum[15]} + 16'(r_rd_data);
        end
    end

    assign dump_checksum = r_checksum;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_dump_accept;
    assign dump_checksum   = '0;
`endif

    assign dump_x       = r_dump_x;
    assign dump_y       = r_dump_y;
    assign dump_colour  = r_rd_data;
    assign dump_valid   = r_dump_valid;
    assign dump_last    = r_dump_last;
    assign busy         = r_busy;
    assign done         = r_done;
    assign plot_count   = r_plot_count;
    assign reject_count = r_reject_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_sink.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_plot_sink
//  Purpose  : Self-checking bench for vga_plot_sink against a behavioural
//             framebuffer model (array + counters + expected beat index).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_plot_sink;

    localparam int c_W    = 160;
    localparam int c_H    = 120;
    localparam int c_NPIX = c_W * c_H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  vga_x = '0;
    logic [6:0]  vga_y = '0;
    logic [2:0]  vga_colour = '0;
    logic        vga_plot = 1'b0;
    logic        clear_start = 1'b0;
    logic        dump_start = 1'b0;
    logic        dump_ready = 1'b0;
    logic [7:0]  dump_x;
    logic [6:0]  dump_y;
    logic [2:0]  dump_colour;
    logic        dump_valid;
    logic        dump_last;
    logic        busy;
    logic        done;
    logic [15:0] plot_count;
    logic [7:0]  reject_count;
    logic [15:0] dump_checksum;

    always #5 clk = ~clk;

    vga_plot_sink #(.SCREEN_W(c_W), .SCREEN_H(c_H), .COLOUR_W(3)) dut (
        .clk(clk), .rst(rst),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .clear_start(clear_start), .dump_start(dump_start),
        .dump_x(dump_x), .dump_y(dump_y), .dump_colour(dump_colour),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_last(dump_last),
        .busy(busy), .done(done),
        .plot_count(plot_count), .reject_count(reject_count),
        .dump_checksum(dump_checksum)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int m_fb [c_NPIX];
    int snap [c_NPIX];
    int cap  [c_NPIX];
    int m_plot = 0;
    int m_rej  = 0;
    bit m_clearing = 1'b0;
    bit m_dumping  = 1'b0;
    bit checks_on  = 1'b0;
    int exp_k = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    function automatic void model_plot(input int x, input int y, input int c);
        if (x < c_W && y < c_H && !m_clearing) begin
            m_fb[y * c_W + x] = c;
            if (m_plot < 65535) m_plot++;
        end else if (m_rej < 255) begin
            m_rej++;
        end
    endfunction

    function automatic logic [15:0] model_checksum();
        logic [15:0] cs = 16'h0000;
        for (int k = 0; k < c_NPIX; k++) cs = {cs[14:0], cs[15]} + 16'(snap[k]);
        return cs;
    endfunction

    // Compare process: counters every cycle, stream beats against the raster model
    always @(negedge clk) begin
        if (checks_on && !rst) begin
            chk("plot_count", int'(plot_count), m_plot);
            chk("reject_count", int'(reject_count), m_rej);
            if (m_dumping && dump_valid) begin
                if (exp_k >= c_NPIX) begin
                    chk("extra_beat", exp_k, c_NPIX - 1);
                end else begin
                    chk("dump_x", int'(dump_x), exp_k % c_W);
                    chk("dump_y", int'(dump_y), exp_k / c_W);
                    chk("dump_colour", int'(dump_colour), snap[exp_k]);
                    chk("dump_last", int'(dump_last), int'(exp_k == c_NPIX - 1));
                    cap[exp_k] = int'(dump_colour);
                    if (dump_ready) exp_k++;
                end
            end
        end
    end

    task automatic do_plot(input int x, input int y, input int c);
        @(posedge clk); #1;
        vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'(c); vga_plot = 1'b1;
        @(posedge clk); #1;
        vga_plot = 1'b0;
        model_plot(x, y, c);
    endtask

    // Back-to-back plots, one per cycle
    task automatic plot_burst(input int n, input int xlo, input int xhi, input int ylo, input int yhi);
        int px = 0, py = 0, pc = 0;
        bit pend = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (pend) model_plot(px, py, pc);
            px = int'($urandom_range(xhi, xlo));
            py = int'($urandom_range(yhi, ylo));
            pc = int'($urandom_range(7, 0));
            vga_x = 8'(px); vga_y = 7'(py); vga_colour = 3'(pc); vga_plot = 1'b1;
            pend = 1'b1;
        end
        @(posedge clk); #1;
        vga_plot = 1'b0;
        if (pend) model_plot(px, py, pc);
    endtask

    task automatic do_clear(input bit both, input bit mid_plot);
        int busy_cycles = 0, dones = 0;
        bit valid_seen = 1'b0, pend = 1'b0;
        @(posedge clk); #1;
        clear_start = 1'b1; dump_start = both;
        @(posedge clk); #1;
        clear_start = 1'b0; dump_start = 1'b0; m_clearing = 1'b1;
        for (int n = 0; n < 19300; n++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) dones++;
            if (dump_valid) valid_seen = 1'b1;
            @(posedge clk); #1;
            if (pend) begin vga_plot = 1'b0; model_plot(3, 3, 1); pend = 1'b0; end
            if (mid_plot && n == 100) begin
                vga_x = 8'd3; vga_y = 7'd3; vga_colour = 3'd1; vga_plot = 1'b1; pend = 1'b1;
            end
        end
        m_clearing = 1'b0;
        for (int k = 0; k < c_NPIX; k++) m_fb[k] = 0;
        chk("clear_busy_cycles", busy_cycles, c_NPIX);
        chk("clear_done_pulses", dones, 1);
        chk("clear_no_dump", int'(valid_seen), 0);
    endtask

    task automatic do_dump(input bit rnd);
        int lat = -1, dones = 0, after = 0, n = 0;
        for (int k = 0; k < c_NPIX; k++) snap[k] = m_fb[k];
        exp_k = 0; m_dumping = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b1; dump_ready = 1'b1;
        while (after < 8 && n < 60000) begin
            @(negedge clk);
            if (dump_valid && lat < 0) lat = n;
            if (done) dones++;
            if (dones > 0) after++;
            n++;
            @(posedge clk); #1;
            dump_start = 1'b0;
            dump_ready = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
        end
        m_dumping = 1'b0;
        @(negedge clk);
        chk("dump_first_valid_latency", lat, 2);
        chk("dump_done_pulses", dones, 1);
        chk("dump_beats", exp_k, c_NPIX);
        chk("dump_busy_after", int'(busy), 0);
        chk("dump_valid_after", int'(dump_valid), 0);
`ifdef VGA_PLOT_SINK_CHECKSUM_EN
        chk("dump_checksum", int'(dump_checksum), int'(model_checksum()));
`else
        chk("dump_checksum", int'(dump_checksum), 0);
`endif
    endtask

    task automatic reset_abort();
        int beats = 0, n = 0, dones = 0;
        for (int k = 0; k < c_NPIX; k++) snap[k] = m_fb[k];
        exp_k = 0; m_dumping = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b1; dump_ready = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
        while (beats < 500 && n < 5000) begin
            @(negedge clk);
            if (dump_valid && dump_ready) beats++;
            n++;
        end
        chk("abort_reached_beat", beats, 500);
        @(posedge clk); #1;
        rst = 1'b1; m_dumping = 1'b0; m_plot = 0; m_rej = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", int'(dump_valid), 0);
        chk("abort_busy", int'(busy), 0);
        for (int i = 0; i < 30; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("abort_no_done", dones, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < c_NPIX; k++) m_fb[k] = 0;
        rst = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_dump_x", int'(dump_x), 0);
        chk("rst_dump_y", int'(dump_y), 0);
        chk("rst_dump_colour", int'(dump_colour), 0);
        chk("rst_dump_valid", int'(dump_valid), 0);
        chk("rst_dump_last", int'(dump_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_plot_count", int'(plot_count), 0);
        chk("rst_reject_count", int'(reject_count), 0);
        chk("rst_checksum", int'(dump_checksum), 0);
        @(posedge clk); #1;
        rst = 1'b0; checks_on = 1'b1;

        do_clear(1'b0, 1'b0);

        do_plot(60, 72, 5);
        do_plot(109, 65, 2);
        do_plot(0, 0, 7);
        @(negedge clk);
        chk("plot_count_three", int'(plot_count), 3);

        do_plot(160, 10, 3);
        do_plot(5, 120, 3);
        do_plot(255, 127, 3);
        @(negedge clk);
        chk("reject_count_three", int'(reject_count), 3);
        chk("plot_count_unchanged", int'(plot_count), 3);

        plot_burst(150, 0, 200, 80, 127);
        plot_burst(260, 160, 255, 0, 127);
        @(negedge clk);
        chk("reject_count_saturated", int'(reject_count), 255);

        do_dump(1'b0);
        chk("beat0_colour", cap[0], 7);
        chk("beat11580_colour", cap[11580], 5);
        chk("beat10509_colour", cap[10509], 2);

        reset_abort();

        do_clear(1'b1, 1'b1);
        @(negedge clk);
        chk("clear_plot_rejected", int'(reject_count), 1);
        do_plot(0, 0, 1);
        do_dump(1'b1);
        chk("final_beat0", cap[0], 1);
        chk("pixel_3_3_cleared", cap[3 * c_W + 3], 0);
`ifdef VGA_PLOT_SINK_CHECKSUM_EN
        chk("checksum_single_pixel", int'(dump_checksum), 32'h8000);
`else
        chk("checksum_disabled", int'(dump_checksum), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_plot_sink.md
Name: vga_plot_sink

Overview:
- Receiving end of the VGA plot interface (x/y/colour/plot) driven by the fillscreen, circle and reuleaux drawing engines.
- Captures every plotted pixel into an internal 160x120x3-bit framebuffer.
- Counts accepted and rejected plots.
- On request, streams the framebuffer back out in raster order over a valid/ready interface, so benches and a readback path can check drawn images without the VGA simulator.

Parameters:
- SCREEN_W, 160, pixel columns; legal x is 0..SCREEN_W-1.
- SCREEN_H, 120, pixel rows; legal y is 0..SCREEN_H-1.
- COLOUR_W, 3, bits per pixel.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- vga_x  in  8  plot column.
- vga_y  in  7  plot row.
- vga_colour  in  COLOUR_W  plot colour.
- vga_plot  in  1  write strobe; one pixel per cycle while high.
- clear_start  in  1  pulse: fill framebuffer with colour 0.
- dump_start  in  1  pulse: stream framebuffer out.
- dump_x  out  8  column of the streamed pixel.
- dump_y  out  7  row of the streamed pixel.
- dump_colour  out  COLOUR_W  stored colour of the streamed pixel.
- dump_valid  out  1  stream beat valid.
- dump_ready  in  1  consumer accepts the beat.
- dump_last  out  1  high on the beat for (159,119).
- busy  out  1  high in CLEAR or DUMP.
- done  out  1  one-cycle pulse when CLEAR or DUMP completes.
- plot_count  out  16  accepted plots, saturates at 0xFFFF.
- reject_count  out  8  dropped plots (out of range or during CLEAR), saturates at 0xFF.
- dump_checksum  out  16  see Optional Feature.

Behaviour:
Reset:
- All outputs are 0 after reset: dump_*, busy, done, both counters, checksum. FSM goes to IDLE.
- Framebuffer contents are not reset; use clear_start.
- Reset mid-CLEAR or mid-DUMP aborts the operation immediately. No done pulse is produced.

FSM states: IDLE, CLEAR, DUMP.

IDLE:
- clear_start goes to CLEAR. dump_start goes to DUMP.
- If both are pulsed in the same cycle, clear_start wins and dump_start is ignored.
- Starts arriving while busy are ignored.

CLEAR:
- Writes colour 0 to one address per cycle in raster order: x increments first, y at wrap.
- Takes 19200 cycles.
- done pulses on the cycle after the (159,119) write. Returns to IDLE.

DUMP:
- Reads through a registered memory port.
- First dump_valid appears 2 cycles after dump_start.
- Once valid is high, dump_x, dump_y, dump_colour and dump_last hold stable until dump_ready is sampled high.
- A beat transfers when valid and ready are both high. Sustained throughput is 1 beat/cycle while ready stays high.
- After the dump_last beat transfers: valid drops, done pulses, FSM returns to IDLE.

Plot capture:
- Evaluated every cycle that vga_plot=1.
- If x<SCREEN_W, y<SCREEN_H and state!=CLEAR: the pixel is written at address y*SCREEN_W+x and plot_count increments.
- Otherwise nothing is written and reject_count increments.
- Plots during DUMP are accepted. If a plot hits the address being read in the same cycle, the read returns the old value.
- Repeated plots to the same pixel keep the last colour.
- Address arithmetic uses at least 15 bits. No wrap-around of x or y into a neighbouring row.

Optional Feature:
- Macro: VGA_PLOT_SINK_CHECKSUM_EN.
- Defined: dump_checksum clears to 0 on dump_start. On each transferred beat it updates as checksum = {checksum[14:0],checksum[15]} + zero-extended dump_colour, modulo 2^16. It holds its value after done.
- Undefined: the port exists but is tied to 0, and no checksum logic is built.

Test Plan:
- rst=1 for 2 cycles -> all outputs 0, state IDLE. Then clear_start -> busy high for 19200 cycles, done pulses once, a following dump returns colour 0 for all 19200 beats.
- After clear, plot (60,72,c=5), (109,65,c=2), (0,0,c=7) -> plot_count=3. Dump with ready always 1 -> beat 0 is colour 7, beat 11580 is colour 5, beat 10509 is colour 2, all others 0, dump_last on beat 19199.
- Plot (160,10), (5,120) and (255,127) -> reject_count=3, plot_count unchanged, framebuffer unchanged.
- Dump with dump_ready toggled 1-0-0-1 pseudo-randomly -> no beat lost or duplicated, outputs stable while ready=0, exactly 19200 transfers.
- clear_start and dump_start in the same cycle -> CLEAR runs. Plot (3,3,c=1) during CLEAR -> rejected, pixel reads 0. Assert rst mid-DUMP at beat 500 -> valid 0 next cycle, no done pulse.
- With VGA_PLOT_SINK_CHECKSUM_EN: only (0,0,c=1) set, dump -> checksum=0x8000 after the final beat. Without the macro -> checksum reads 0.
